// File: rtl/ft_rx_reader_if.sv
// Signal bundle between the FT600 sync-245 receive reader and its surroundings:
// the FT600 bus pins on one side, the FWFT stream and status on the other.
interface ft_rx_reader_if #(
  parameter int DATA_W = 16,
  parameter int BE_W   = 2,
  parameter int DEPTH  = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] data;
  logic [BE_W-1:0]   be;
  logic              rxf_n;
  logic              oe_n;
  logic              rd_n;
  logic              wr_n;
  logic [DATA_W-1:0] m_data;
  logic [BE_W-1:0]   m_be;
  logic              m_valid;
  logic              m_ready;
  logic [LVL_W-1:0]  level;
  logic              ovf;
  logic [31:0]       rx_count;

  // Reader side.
  modport master (
    input  data, be, rxf_n, m_ready,
    output oe_n, rd_n, wr_n, m_data, m_be, m_valid, level, ovf, rx_count
  );

  // FT600 chip plus stream consumer side.
  modport slave (
    output data, be, rxf_n, m_ready,
    input  oe_n, rd_n, wr_n, m_data, m_be, m_valid, level, ovf, rx_count
  );
endinterface

// File: rtl/ft_rx_reader.sv
// FT600 sync-245 receive reader: drives oe_n/rd_n, captures words straight
// off the bus into a small first-word-fall-through FIFO.
module ft_rx_reader #(
  parameter int DATA_W = 16,
  parameter int BE_W   = 2,
  parameter int DEPTH  = 8
) (
  input logic            clk,
  input logic            rst,
  ft_rx_reader_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = DATA_W + BE_W;

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] ARM_MAX  = LW'(DEPTH - 4);
  localparam logic [LW-1:0] STOP_LVL = LW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ARM, READ, DRAIN} state_t;

  state_t          state_reg;
  logic            oe_n_reg;
  logic            rd_n_reg;

  logic [WW-1:0]   mem [DEPTH];
  logic [WW-1:0]   head_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic            ovf_reg;
  logic [31:0]     rx_count_reg;

  logic            push;
  logic            pop;
  logic            push_acc;
  logic            drop;
  logic [LW-1:0]   level_next;
  logic [AW-1:0]   rd_ptr_next;
  logic [WW-1:0]   wdata;

  always_comb begin
    push        = 1'b0;
    pop         = 1'b0;
    push_acc    = 1'b0;
    drop        = 1'b0;
    level_next  = level_reg;
    rd_ptr_next = rd_ptr_reg;
    wdata       = {bus.data, bus.be};
    if (!rst) begin
      push       = (state_reg == READ) && !bus.rxf_n;
      pop        = (level_reg != '0) && bus.m_ready;
      push_acc   = push && ((level_reg != FULL_LVL) || pop);
      drop       = push && !push_acc;
      level_next = level_reg + LW'(push_acc) - LW'(pop);
      if (pop)
        rd_ptr_next = rd_ptr_reg + AW'(1);
    end
  end

  // Output enable leads the read strobe by one cycle (ARM) and trails it
  // by one cycle (DRAIN) so the FT600 never drives into a read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      oe_n_reg  <= 1'b1;
      rd_n_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!bus.rxf_n && (level_reg <= ARM_MAX)) begin
            state_reg <= ARM;
            oe_n_reg  <= 1'b0;
            rd_n_reg  <= 1'b1;
          end
        end
        ARM: begin
          if (!bus.rxf_n) begin
            state_reg <= READ;
            oe_n_reg  <= 1'b0;
            rd_n_reg  <= 1'b0;
          end else begin
            state_reg <= IDLE;
            oe_n_reg  <= 1'b1;
            rd_n_reg  <= 1'b1;
          end
        end
        READ: begin
          if (bus.rxf_n || (level_next >= STOP_LVL)) begin
            state_reg <= DRAIN;
            oe_n_reg  <= 1'b0;
            rd_n_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          oe_n_reg  <= 1'b1;
          rd_n_reg  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      ovf_reg      <= 1'b0;
      rx_count_reg <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr_reg   <= wr_ptr_reg + AW'(1);
        rx_count_reg <= rx_count_reg + 32'd1;
      end
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      if (drop)
        ovf_reg <= 1'b1;
    end
  end

  // Registered read at the look-ahead pointer keeps the head word current;
  // a write landing on that same slot is forwarded so an empty FIFO shows
  // its first word one cycle after capture.
  always_ff @(posedge clk) begin
    if (push_acc)
      mem[wr_ptr_reg] <= wdata;
    if (push_acc && (wr_ptr_reg == rd_ptr_next))
      head_reg <= wdata;
    else
      head_reg <= mem[rd_ptr_next];
  end

  assign bus.oe_n     = oe_n_reg;
  assign bus.rd_n     = rd_n_reg;
  assign bus.wr_n     = 1'b1;
  assign bus.m_data   = head_reg[WW-1:BE_W];
  assign bus.m_be     = head_reg[BE_W-1:0];
  assign bus.m_valid  = (level_reg != '0);
  assign bus.level    = level_reg;
  assign bus.ovf      = ovf_reg;
  assign bus.rx_count = rx_count_reg;
endmodule
